// File: rtl/traffic_light_monitor.sv
// Safety monitor for the traffic_light lamp outputs: decodes lamp lines back into
// controller phases, checks combinations, phase order and dwell time, latches a sticky fault.
module traffic_light_monitor #(
    parameter int unsigned GREEN_CYCLES   = 480000000,
    parameter int unsigned YELLOW_CYCLES  = 80000000,
    parameter int unsigned RED_RED_CYCLES = 32000000,
    parameter int unsigned TOL            = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        red1,
    input  logic        yellow1,
    input  logic        green1,
    input  logic        red2,
    input  logic        yellow2,
    input  logic        green2,
    input  logic        fault_clr,
    output logic        fault,
    output logic [2:0]  fault_code,
    output logic [3:0]  phase,
    output logic        synced,
    output logic [15:0] cycles_ok
);

    typedef enum logic [3:0] {
        PH_ILLEGAL = 4'b0000,
        PH_G1R2    = 4'b0001,
        PH_Y1R2    = 4'b0010,
        PH_RR      = 4'b0011,
        PH_R1G2    = 4'b0100,
        PH_R1Y2    = 4'b1000
    } phase_t;

    typedef enum logic [1:0] {
        DIR_UNKNOWN,
        DIR_FROM_Y1,
        DIR_FROM_Y2
    } dir_t;

    typedef enum logic [2:0] {
        FC_NONE    = 3'd0,
        FC_ILLEGAL = 3'd1,
        FC_BAD_TRN = 3'd2,
        FC_SHORT   = 3'd3,
        FC_LONG    = 3'd4
    } fcode_t;

    logic [5:0]  r_samp;
    logic        r_valid;
    phase_t      r_phase;
    logic [31:0] r_dwell;
    dir_t        r_dir;
    logic        r_synced;
    logic        r_fault;
    fcode_t      r_code;
    logic [15:0] r_cycles;

    phase_t      w_dec;
    logic [31:0] w_exp;
    logic [31:0] w_min;
    logic [31:0] w_lim;
    logic [31:0] w_dwell_inc;
    logic [31:0] w_dwell_nxt;
    logic        w_change;
    logic        w_dec_legal;
    logic        w_cur_legal;
    logic        w_allowed;
    logic        w_err_illegal;
    logic        w_err_bad;
    logic        w_err_short;
    logic        w_err_long;
    fcode_t      w_new_code;
    logic        w_fault_nxt;
    fcode_t      w_code_nxt;
    logic        w_synced_nxt;
    dir_t        w_dir_nxt;
    logic [15:0] w_cycles_nxt;

    always_comb begin
        case (r_samp)
            6'b001_100: w_dec = PH_G1R2;
            6'b010_100: w_dec = PH_Y1R2;
            6'b100_100: w_dec = PH_RR;
            6'b100_001: w_dec = PH_R1G2;
            6'b100_010: w_dec = PH_R1Y2;
            default:    w_dec = PH_ILLEGAL;
        endcase
    end

    always_comb begin
        case (r_phase)
            PH_G1R2, PH_R1G2: w_exp = 32'(GREEN_CYCLES);
            PH_Y1R2, PH_R1Y2: w_exp = 32'(YELLOW_CYCLES);
            PH_RR:            w_exp = 32'(RED_RED_CYCLES);
            default:          w_exp = '0;
        endcase
        w_min = w_exp - 32'(TOL);
        w_lim = w_exp + 32'(TOL) + 32'd1;
    end

    always_comb begin
        w_change    = (w_dec != r_phase);
        w_dec_legal = (w_dec != PH_ILLEGAL);
        w_cur_legal = (r_phase != PH_ILLEGAL);
        w_dwell_inc = (r_dwell == '1) ? r_dwell : r_dwell + 32'd1;
        w_dwell_nxt = w_change ? 32'd1 : w_dwell_inc;

        w_allowed = 1'b0;
        case (r_phase)
            PH_G1R2: w_allowed = (w_dec == PH_Y1R2);
            PH_Y1R2: w_allowed = (w_dec == PH_RR);
            PH_R1G2: w_allowed = (w_dec == PH_R1Y2);
            PH_R1Y2: w_allowed = (w_dec == PH_RR);
            PH_RR:   w_allowed = ((w_dec == PH_R1G2) && (r_dir != DIR_FROM_Y2)) ||
                                 ((w_dec == PH_G1R2) && (r_dir != DIR_FROM_Y1));
            default: w_allowed = 1'b0;
        endcase

        // r_valid masks the all-zero sample register seen on the first edge after reset
        w_err_illegal = r_valid && !w_dec_legal;
        w_err_bad     = w_change && w_cur_legal && w_dec_legal && !w_allowed;
        w_err_short   = r_synced && w_change && w_cur_legal && (r_dwell < w_min);
        w_err_long    = r_synced && !w_change && w_cur_legal && (w_dwell_inc == w_lim);

        if (w_err_illegal)    w_new_code = FC_ILLEGAL;
        else if (w_err_bad)   w_new_code = FC_BAD_TRN;
        else if (w_err_short) w_new_code = FC_SHORT;
        else if (w_err_long)  w_new_code = FC_LONG;
        else                  w_new_code = FC_NONE;

        w_fault_nxt = r_fault;
        w_code_nxt  = r_code;
        if ((w_new_code != FC_NONE) && (!r_fault || fault_clr)) begin
            w_fault_nxt = 1'b1;
            w_code_nxt  = w_new_code;
        end else if (fault_clr) begin
            w_fault_nxt = 1'b0;
            w_code_nxt  = FC_NONE;
        end

        w_synced_nxt = r_synced;
        if (!w_dec_legal)
            w_synced_nxt = 1'b0;
        else if (w_change && w_cur_legal)
            w_synced_nxt = 1'b1;

        w_dir_nxt = r_dir;
        if (!w_dec_legal) begin
            w_dir_nxt = DIR_UNKNOWN;
        end else if (w_change && (w_dec == PH_RR)) begin
            case (r_phase)
                PH_Y1R2: w_dir_nxt = DIR_FROM_Y1;
                PH_R1Y2: w_dir_nxt = DIR_FROM_Y2;
                default: w_dir_nxt = DIR_UNKNOWN;
            endcase
        end

        w_cycles_nxt = r_cycles;
        if (w_change && (w_dec == PH_G1R2) && w_cur_legal && !w_err_bad && !w_err_short &&
            r_synced && !r_fault && (r_cycles != '1))
            w_cycles_nxt = r_cycles + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_samp   <= '0;
            r_valid  <= 1'b0;
            r_phase  <= PH_ILLEGAL;
            r_dwell  <= '0;
            r_dir    <= DIR_UNKNOWN;
            r_synced <= 1'b0;
            r_fault  <= 1'b0;
            r_code   <= FC_NONE;
            r_cycles <= '0;
        end else begin
            r_samp   <= {red1, yellow1, green1, red2, yellow2, green2};
            r_valid  <= 1'b1;
            r_phase  <= w_dec;
            r_dwell  <= w_dwell_nxt;
            r_dir    <= w_dir_nxt;
            r_synced <= w_synced_nxt;
            r_fault  <= w_fault_nxt;
            r_code   <= w_code_nxt;
            r_cycles <= w_cycles_nxt;
        end
    end

    assign fault      = r_fault;
    assign fault_code = r_code;
    assign phase      = r_phase;
    assign synced     = r_synced;
    assign cycles_ok  = r_cycles;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Bench for traffic_light_monitor: per-cycle lamp stimulus with expected phase/fault/sync
// values queued at drive time and compared two edges later.
module tb_traffic_light_monitor;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        red1, yellow1, green1, red2, yellow2, green2;
    logic        fault_clr;
    logic        fault;
    logic [2:0]  fault_code;
    logic [3:0]  phase;
    logic        synced;
    logic [15:0] cycles_ok;

    localparam logic [5:0] P_G1R2 = 6'b001_100;
    localparam logic [5:0] P_Y1R2 = 6'b010_100;
    localparam logic [5:0] P_RR   = 6'b100_100;
    localparam logic [5:0] P_R1G2 = 6'b100_001;
    localparam logic [5:0] P_R1Y2 = 6'b100_010;
    localparam logic [5:0] P_CONF = 6'b001_101;

    typedef struct {
        int unsigned due;
        logic [3:0]  ph;
        logic        f;
        logic [2:0]  c;
        logic        s;
    } exp_t;

    exp_t        q[$];
    int unsigned n_edge = 0;
    int          errors = 0;
    int          checks = 0;
    logic        pending_clr;
    string       tname;

    traffic_light_monitor #(
        .GREEN_CYCLES   (20),
        .YELLOW_CYCLES  (5),
        .RED_RED_CYCLES (3),
        .TOL            (1)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .red1       (red1),
        .yellow1    (yellow1),
        .green1     (green1),
        .red2       (red2),
        .yellow2    (yellow2),
        .green2     (green2),
        .fault_clr  (fault_clr),
        .fault      (fault),
        .fault_code (fault_code),
        .phase      (phase),
        .synced     (synced),
        .cycles_ok  (cycles_ok)
    );

    always #5 clk = ~clk;

    always @(posedge clk) n_edge <= n_edge + 1;

    function automatic logic [3:0] ph_of(input logic [5:0] p);
        case (p)
            P_G1R2:  return 4'b0001;
            P_Y1R2:  return 4'b0010;
            P_RR:    return 4'b0011;
            P_R1G2:  return 4'b0100;
            P_R1Y2:  return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    task automatic drive(input logic [5:0] p);
        {red1, yellow1, green1, red2, yellow2, green2} = p;
    endtask

    task automatic drain();
        while (q.size() > 0 && q[0].due <= n_edge) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (phase !== e.ph || fault !== e.f || fault_code !== e.c || synced !== e.s) begin
                errors++;
                $display("FAIL %s edge %0d: got phase=%b fault=%b code=%0d synced=%b, want phase=%b fault=%b code=%0d synced=%b",
                         tname, n_edge, phase, fault, fault_code, synced, e.ph, e.f, e.c, e.s);
            end
        end
    endtask

    // One call = n clock cycles of pattern p; clr asserts fault_clr on the edge that evaluates this step
    task automatic hold(input logic [5:0] p, input int unsigned n, input logic f,
                        input logic [2:0] c, input logic s, input logic clr = 1'b0);
        for (int unsigned i = 0; i < n; i++) begin
            exp_t e;
            drive(p);
            fault_clr   = pending_clr;
            pending_clr = clr;
            e.due = n_edge + 2;
            e.ph  = ph_of(p);
            e.f   = f;
            e.c   = c;
            e.s   = s;
            q.push_back(e);
            @(posedge clk);
            #1;
            drain();
        end
    endtask

    task automatic flush();
        fault_clr   = pending_clr;
        pending_clr = 1'b0;
        for (int i = 0; i < 8 && q.size() > 0; i++) begin
            @(posedge clk);
            #1;
            fault_clr = 1'b0;
            drain();
        end
        if (q.size() != 0) begin
            errors++;
            checks++;
            $display("FAIL %s flush: %0d expectations never matured", tname, q.size());
            q.delete();
        end
    endtask

    task automatic apply_reset(input logic [5:0] p);
        rst_n       = 1'b0;
        drive(p);
        fault_clr   = 1'b0;
        pending_clr = 1'b0;
        q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tname = "reset";
        rst_n = 1'b1;
        fault_clr = 1'b0;
        pending_clr = 1'b0;
        drive(P_R1G2);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || phase !== 4'd0 || synced !== 1'b0 || cycles_ok !== 16'd0) begin
            errors++;
            $display("FAIL reset_state: got fault=%b code=%0d phase=%b synced=%b cycles_ok=%0d, want all zero",
                     fault, fault_code, phase, synced, cycles_ok);
        end
    endtask

    task automatic test_nominal();
        tname = "nominal";
        apply_reset(P_R1G2);
        hold(P_R1G2, 5, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            hold(P_R1Y2, 5, 0, 0, 1);
            hold(P_RR,   3, 0, 0, 1);
            if (k < 2) begin
                hold(P_G1R2, 20, 0, 0, 1);
                checks++;
                if (cycles_ok !== 16'(k + 1)) begin
                    errors++;
                    $display("FAIL nominal_count: got cycles_ok=%0d want %0d", cycles_ok, k + 1);
                end
                hold(P_Y1R2, 5,  0, 0, 1);
                hold(P_RR,   3,  0, 0, 1);
                hold(P_R1G2, 20, 0, 0, 1);
            end else begin
                hold(P_G1R2, 3, 0, 0, 1);
            end
        end
        flush();
        checks++;
        if (cycles_ok !== 16'd3 || fault !== 1'b0) begin
            errors++;
            $display("FAIL nominal_end: got cycles_ok=%0d fault=%b want 3 and 0", cycles_ok, fault);
        end
    endtask

    task automatic test_conflict();
        tname = "conflict";
        apply_reset(P_G1R2);
        hold(P_G1R2, 3, 0, 0, 0);
        hold(P_CONF, 1, 1, 1, 0);
        hold(P_G1R2, 4, 1, 1, 0);
        hold(P_G1R2, 1, 0, 0, 0, 1);
        hold(P_G1R2, 10, 0, 0, 0);
        hold(P_Y1R2, 5,  0, 0, 1);
        hold(P_RR,   3,  0, 0, 1);
        hold(P_R1G2, 20, 0, 0, 1);
        hold(P_R1Y2, 5,  0, 0, 1);
        hold(P_RR,   3,  0, 0, 1);
        hold(P_G1R2, 3,  0, 0, 1);
        flush();
        checks++;
        if (cycles_ok !== 16'd1 || fault !== 1'b0) begin
            errors++;
            $display("FAIL conflict_resync: got cycles_ok=%0d fault=%b want 1 and 0", cycles_ok, fault);
        end
    endtask

    task automatic test_order();
        tname = "order_skip_rr";
        apply_reset(P_G1R2);
        hold(P_G1R2, 3, 0, 0, 0);
        hold(P_Y1R2, 5, 0, 0, 1);
        hold(P_R1G2, 2, 1, 2, 1);
        flush();

        tname = "order_direction";
        apply_reset(P_G1R2);
        hold(P_G1R2, 3, 0, 0, 0);
        hold(P_Y1R2, 5, 0, 0, 1);
        hold(P_RR,   3, 0, 0, 1);
        hold(P_G1R2, 2, 1, 2, 1);
        flush();

        tname = "order_unknown_dir";
        apply_reset(P_RR);
        hold(P_RR,   2, 0, 0, 0);
        hold(P_G1R2, 3, 0, 0, 1);
        flush();
    endtask

    task automatic test_dwell();
        tname = "dwell_short";
        apply_reset(P_G1R2);
        hold(P_G1R2, 3, 0, 0, 0);
        hold(P_Y1R2, 3, 0, 0, 1);
        hold(P_RR,   2, 1, 3, 1);
        flush();

        tname = "dwell_long";
        apply_reset(P_R1G2);
        hold(P_R1G2, 3,  0, 0, 0);
        hold(P_R1Y2, 5,  0, 0, 1);
        hold(P_RR,   3,  0, 0, 1);
        hold(P_G1R2, 21, 0, 0, 1);
        hold(P_G1R2, 1,  1, 4, 1);
        hold(P_G1R2, 2,  1, 4, 1);
        flush();
        checks++;
        if (cycles_ok !== 16'd1) begin
            errors++;
            $display("FAIL dwell_long_count: got cycles_ok=%0d want 1", cycles_ok);
        end

        tname = "dwell_edges";
        apply_reset(P_R1G2);
        hold(P_R1G2, 3,  0, 0, 0);
        hold(P_R1Y2, 5,  0, 0, 1);
        hold(P_RR,   3,  0, 0, 1);
        hold(P_G1R2, 19, 0, 0, 1);
        hold(P_Y1R2, 5,  0, 0, 1);
        hold(P_RR,   3,  0, 0, 1);
        hold(P_R1G2, 21, 0, 0, 1);
        hold(P_R1Y2, 5,  0, 0, 1);
        hold(P_RR,   3,  0, 0, 1);
        hold(P_G1R2, 3,  0, 0, 1);
        flush();
        checks++;
        if (cycles_ok !== 16'd2 || fault !== 1'b0) begin
            errors++;
            $display("FAIL dwell_edges_end: got cycles_ok=%0d fault=%b want 2 and 0", cycles_ok, fault);
        end
    endtask

    task automatic test_priority();
        tname = "prio_bad_short";
        apply_reset(P_G1R2);
        hold(P_G1R2, 3, 0, 0, 0);
        hold(P_Y1R2, 5, 0, 0, 1);
        hold(P_RR,   1, 0, 0, 1);
        hold(P_G1R2, 2, 1, 2, 1);
        flush();

        tname = "prio_clr_long";
        apply_reset(P_R1G2);
        hold(P_R1G2, 3,  0, 0, 0);
        hold(P_R1Y2, 3,  0, 0, 1);
        hold(P_RR,   3,  1, 3, 1);
        hold(P_G1R2, 21, 1, 3, 1);
        hold(P_G1R2, 1,  1, 4, 1, 1);
        hold(P_G1R2, 1,  1, 4, 1);
        hold(P_G1R2, 1,  0, 0, 1, 1);
        hold(P_G1R2, 1,  0, 0, 1);
        flush();
        checks++;
        if (cycles_ok !== 16'd0) begin
            errors++;
            $display("FAIL prio_count: got cycles_ok=%0d want 0", cycles_ok);
        end
    endtask

    task automatic test_reset_midrun();
        tname = "reset_midrun";
        apply_reset(P_R1G2);
        hold(P_R1G2, 3,  0, 0, 0);
        hold(P_R1Y2, 5,  0, 0, 1);
        hold(P_RR,   3,  0, 0, 1);
        hold(P_G1R2, 20, 0, 0, 1);
        hold(P_Y1R2, 3,  0, 0, 1);
        hold(P_RR,   3,  1, 3, 1);
        hold(P_R1G2, 20, 1, 3, 1);
        hold(P_R1Y2, 5,  1, 3, 1);
        hold(P_RR,   3,  1, 3, 1);
        hold(P_G1R2, 5,  1, 3, 1);
        checks++;
        if (fault !== 1'b1 || cycles_ok !== 16'd1) begin
            errors++;
            $display("FAIL reset_midrun_pre: got fault=%b cycles_ok=%0d want 1 and 1", fault, cycles_ok);
        end
        #2 rst_n = 1'b0;
        q.delete();
        #1;
        checks++;
        if (fault !== 1'b0 || fault_code !== 3'd0 || phase !== 4'd0 || synced !== 1'b0 || cycles_ok !== 16'd0) begin
            errors++;
            $display("FAIL reset_async: got fault=%b code=%0d phase=%b synced=%b cycles_ok=%0d, want all zero",
                     fault, fault_code, phase, synced, cycles_ok);
        end

        tname = "reset_partial";
        apply_reset(P_Y1R2);
        hold(P_Y1R2, 1, 0, 0, 0);
        hold(P_RR,   3, 0, 0, 1);
        hold(P_R1G2, 3, 0, 0, 1);
        flush();
        checks++;
        if (fault !== 1'b0) begin
            errors++;
            $display("FAIL reset_partial_fault: got fault=%b want 0", fault);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_conflict();
        test_order();
        test_dwell();
        test_priority();
        test_reset_midrun();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached in %s", tname);
        $fatal(1, "time limit");
    end

endmodule
